// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: carries instruction word and PC+4 with a valid bit,
// supports stall/flush, and times stall episodes with a periodic or one-shot pulse.
module pipe_stage_reg #(
  parameter int unsigned         DATA_W    = 32,
  parameter int unsigned         PC_W      = 32,
  parameter logic [DATA_W-1:0]   NOP_WORD  = '0,
  parameter int unsigned         STALL_CNT = 3,
  parameter bit                  ONE_SHOT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc4,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc4,
  output logic              start,
  output logic              stall_busy,
  output logic [15:0]       stall_total
);

  localparam int unsigned      CNT_W    = (STALL_CNT > 1) ? $clog2(STALL_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_CNT - 1);

  logic [CNT_W-1:0] cnt;
  logic             fired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_instr   <= NOP_WORD;
      out_pc4     <= '0;
      start       <= 1'b0;
      stall_busy  <= 1'b0;
      stall_total <= '0;
      cnt         <= '0;
      fired       <= 1'b0;
    end else begin
      // The statistic counts every stalled edge, flushed or not.
      if (stall && (stall_total != 16'hFFFF))
        stall_total <= stall_total + 16'd1;

      if (flush) begin
        out_valid  <= 1'b0;
        out_instr  <= NOP_WORD;
        if (!stall)
          out_pc4  <= in_pc4;
        cnt        <= '0;
        fired      <= 1'b0;
        start      <= 1'b0;
        stall_busy <= 1'b0;
      end else if (stall) begin
        stall_busy <= 1'b1;
        if (cnt == CNT_LAST) begin
          if (!ONE_SHOT) begin
            start <= 1'b1;
            cnt   <= '0;
          end else begin
            // One-shot parks at the terminal count until the episode ends.
            start <= !fired;
            fired <= 1'b1;
          end
        end else begin
          cnt   <= cnt + 1'b1;
          start <= 1'b0;
        end
      end else begin
        out_valid  <= in_valid;
        out_instr  <= in_valid ? in_instr : NOP_WORD;
        out_pc4    <= in_pc4;
        cnt        <= '0;
        fired      <= 1'b0;
        start      <= 1'b0;
        stall_busy <= 1'b0;
      end
    end
  end

endmodule
